cp_inserter: RTL and testbench

- Sits directly downstream of the IFFT that consumes the QAM mapper's 2N-sample Hermitian frames.
- Buffers each time-domain frame of FFT_LEN 32-bit samples and re-emits it with a cyclic prefix: the last CP_LEN samples first, then the full frame.
- Ping-pong buffering lets one frame be written while the previous one is read out, so the stream to the DAC path runs continuously.

---
 rtl/cp_pkg.sv | 22 ++
 rtl/cp_frame_ram.sv | 27 ++
 rtl/cp_inserter.sv | 186 ++++++++++++++++++
 tb/tb_cp_inserter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp_pkg.sv
// Shared types for the cyclic-prefix inserter: sample packing, read-FSM states, index sizing.
// Pure definitions, no logic.
package cp_pkg;

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
    } sample_t;

    localparam int SAMPLE_W = $bits(sample_t);

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_PREFIX = 2'd1,
        RD_BODY   = 2'd2
    } rd_state_e;

    function automatic int idx_width(input int fft_len);
        return $clog2(fft_len);
    endfunction

endpackage

// File: rtl/cp_frame_ram.sv
// Two-bank frame store: one write port, one registered read port; addr = {bank, idx}.
// Read data appears the cycle after rd_en and holds while rd_en is low.
module cp_frame_ram #(
    parameter int ADDR_W = 5,
    parameter int W      = 32
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [W-1:0]      wr_dat,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [W-1:0]      rd_dat
);

    logic [W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/cp_inserter.sv
// Ping-pong frame buffer that replays the last CP_LEN samples ahead of each FFT_LEN-sample frame.
// First output 2 cycles after the completing input beat; input stalls while the write bank is still full.
module cp_inserter
    import cp_pkg::*;
#(
    parameter int FFT_LEN = 16,
    parameter int CP_LEN  = 4,
    parameter int W       = SAMPLE_W
) (
    input  logic         aclk,
    input  logic         reset,
    input  logic [W-1:0] s_data_in,
    input  logic         s_dvalid,
    input  logic         s_dlast,
    output logic         s_dready,
    output logic [W-1:0] m_data_out,
    output logic         m_dvalid,
    input  logic         m_dready,
    output logic         m_dlast,
    output logic         frame_err
);

    localparam int IDX_W = idx_width(FFT_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FFT_LEN - 1);
    localparam logic [IDX_W-1:0] PFX_START = IDX_W'(FFT_LEN - CP_LEN);
    localparam rd_state_e        START_STATE = (CP_LEN == 0) ? RD_BODY : RD_PREFIX;
    localparam logic [IDX_W-1:0] START_IDX   = (CP_LEN == 0) ? '0 : PFX_START;

    logic [1:0]       full_q, full_d;
    logic             wr_bank_q, wr_bank_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic             frame_err_q, frame_err_d;

    rd_state_e        state_q, state_d;
    logic             rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;

    logic             rv_q, rv_d;
    logic             r_last_q, r_last_d;
    logic             m_dvalid_q, m_dvalid_d;
    logic             m_dlast_q, m_dlast_d;
    logic [W-1:0]     m_data_q, m_data_d;

    logic             wr_fire;
    logic             out_load;
    logic             rd_active;
    logic             rd_issue;
    rd_state_e        cur_state;
    logic [IDX_W-1:0] cur_idx;
    logic             cur_last;
    logic [W-1:0]     ram_rd_dat;

    assign s_dready = ~full_q[wr_bank_q];
    assign wr_fire  = s_dvalid & s_dready;
    assign out_load = ~m_dvalid_q | m_dready;

    always_comb begin
        full_d      = full_q;
        wr_bank_d   = wr_bank_q;
        wr_idx_d    = wr_idx_q;
        frame_err_d = 1'b0;
        state_d     = state_q;
        rd_bank_d   = rd_bank_q;
        rd_idx_d    = rd_idx_q;
        cur_last    = 1'b0;

        if (wr_fire) begin
            if (wr_idx_q == IDX_LAST) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                wr_idx_d          = '0;
                frame_err_d       = ~s_dlast;
            end else if (s_dlast) begin
                frame_err_d = 1'b1;
                wr_idx_d    = '0;
            end else begin
                wr_idx_d = wr_idx_q + IDX_W'(1);
            end
        end

        // IDLE issues the frame's first read itself so the 2-cycle latency holds.
        rd_active = (state_q != RD_IDLE) || full_q[rd_bank_q];
        cur_state = (state_q == RD_IDLE) ? START_STATE : state_q;
        cur_idx   = (state_q == RD_IDLE) ? START_IDX : rd_idx_q;
        rd_issue  = rd_active && (~rv_q || out_load);

        if (rd_issue) begin
            if (cur_state == RD_PREFIX) begin
                if (cur_idx == IDX_LAST) begin
                    state_d  = RD_BODY;
                    rd_idx_d = '0;
                end else begin
                    state_d  = RD_PREFIX;
                    rd_idx_d = cur_idx + IDX_W'(1);
                end
            end else if (cur_idx == IDX_LAST) begin
                cur_last          = 1'b1;
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
                if (full_d[~rd_bank_q]) begin
                    state_d  = START_STATE;
                    rd_idx_d = START_IDX;
                end else begin
                    state_d  = RD_IDLE;
                    rd_idx_d = '0;
                end
            end else begin
                state_d  = RD_BODY;
                rd_idx_d = cur_idx + IDX_W'(1);
            end
        end
    end

    // RAM output acts as a one-entry stage; it holds while the output register is stalled.
    always_comb begin
        rv_d       = rv_q;
        r_last_d   = r_last_q;
        m_dvalid_d = m_dvalid_q;
        m_dlast_d  = m_dlast_q;
        m_data_d   = m_data_q;

        if (rd_issue) begin
            rv_d     = 1'b1;
            r_last_d = cur_last;
        end else if (out_load) begin
            rv_d = 1'b0;
        end

        if (out_load) begin
            m_dvalid_d = rv_q;
            m_dlast_d  = rv_q & r_last_q;
            if (rv_q) begin
                m_data_d = ram_rd_dat;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            full_q      <= '0;
            wr_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
            frame_err_q <= 1'b0;
            state_q     <= RD_IDLE;
            rd_bank_q   <= 1'b0;
            rd_idx_q    <= '0;
            rv_q        <= 1'b0;
            r_last_q    <= 1'b0;
            m_dvalid_q  <= 1'b0;
            m_dlast_q   <= 1'b0;
            m_data_q    <= '0;
        end else begin
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            wr_idx_q    <= wr_idx_d;
            frame_err_q <= frame_err_d;
            state_q     <= state_d;
            rd_bank_q   <= rd_bank_d;
            rd_idx_q    <= rd_idx_d;
            rv_q        <= rv_d;
            r_last_q    <= r_last_d;
            m_dvalid_q  <= m_dvalid_d;
            m_dlast_q   <= m_dlast_d;
            m_data_q    <= m_data_d;
        end
    end

    cp_frame_ram #(
        .ADDR_W (IDX_W + 1),
        .W      (W)
    ) u_ram (
        .clk     (aclk),
        .wr_en   (wr_fire),
        .wr_addr ({wr_bank_q, wr_idx_q}),
        .wr_dat  (s_data_in),
        .rd_en   (rd_issue),
        .rd_addr ({rd_bank_q, cur_idx}),
        .rd_dat  (ram_rd_dat)
    );

    assign m_data_out = m_data_q;
    assign m_dvalid   = m_dvalid_q;
    assign m_dlast    = m_dlast_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_cp_inserter.sv
// Randomised and directed bench for cp_inserter with a frame-level scoreboard; a second CP_LEN=0 instance checks pass-through framing.
module tb_cp_inserter;

    localparam int N  = 16;
    localparam int CP = 4;

    logic        aclk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] s_data_in = '0;
    logic        s_dvalid = 1'b0;
    logic        s_dlast = 1'b0;
    logic        s_dready;
    logic [31:0] m_data_out;
    logic        m_dvalid;
    logic        m_dready = 1'b1;
    logic        m_dlast;
    logic        frame_err;

    logic [31:0] z_s_data = '0;
    logic        z_s_dvalid = 1'b0;
    logic        z_s_dlast = 1'b0;
    logic        z_s_dready;
    logic [31:0] z_m_data;
    logic        z_m_dvalid;
    logic        z_m_dready = 1'b1;
    logic        z_m_dlast;
    logic        z_frame_err;

    initial forever #5 aclk = ~aclk;

    cp_inserter #(.FFT_LEN(N), .CP_LEN(CP)) dut (
        .aclk(aclk), .reset(reset),
        .s_data_in(s_data_in), .s_dvalid(s_dvalid), .s_dlast(s_dlast), .s_dready(s_dready),
        .m_data_out(m_data_out), .m_dvalid(m_dvalid), .m_dready(m_dready), .m_dlast(m_dlast),
        .frame_err(frame_err)
    );

    cp_inserter #(.FFT_LEN(N), .CP_LEN(0)) dut0 (
        .aclk(aclk), .reset(reset),
        .s_data_in(z_s_data), .s_dvalid(z_s_dvalid), .s_dlast(z_s_dlast), .s_dready(z_s_dready),
        .m_data_out(z_m_data), .m_dvalid(z_m_dvalid), .m_dready(z_m_dready), .m_dlast(z_m_dlast),
        .frame_err(z_frame_err)
    );

    int chk_cnt = 0;
    int pass_cnt = 0;
    int cyc = 0;
    bit mon_en = 0;
    bit bp_en = 0;

    // Reference model: partial input frame and the expected output stream {last, data}.
    logic [31:0] part_q[$];
    logic [32:0] exp_q[$];
    logic [32:0] e;
    logic        err_pend = 1'b0;
    logic        hold_pend = 1'b0;
    logic [31:0] hold_dat;
    logic        hold_last;

    int beat_cnt = 0, err_cnt = 0, last_cnt = 0;
    int first_vld_edge = -1, in_done_edge = -1;
    int vld_first = -1, vld_last = -1, vld_cnt = 0;
    bit sdr_low_seen = 0;
    logic [31:0] act_log[$];
    logic [32:0] z_q[$];

    task automatic check(input string name, input longint act, input longint exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(posedge aclk) cyc <= cyc + 1;

    initial forever begin
        @(posedge aclk);
        #1;
        m_dready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge aclk) begin
        if (mon_en) begin
            check("frame_err", frame_err, err_pend);
            if (reset) begin
                exp_q.delete();
                part_q.delete();
                err_pend = 1'b0;
                hold_pend = 1'b0;
            end else begin
                if (frame_err) err_cnt++;
                if (hold_pend) begin
                    check("hold_vld", m_dvalid, 1);
                    check("hold_dat", m_data_out, hold_dat);
                    check("hold_last", m_dlast, hold_last);
                end
                if (m_dvalid) begin
                    if (first_vld_edge < 0) first_vld_edge = cyc;
                    if (vld_first < 0) vld_first = cyc;
                    vld_last = cyc;
                    vld_cnt++;
                end
                if (m_dvalid && m_dready) begin
                    check("beat_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("out_dat", m_data_out, e[31:0]);
                        check("out_last", m_dlast, e[32]);
                    end
                    act_log.push_back(m_data_out);
                    beat_cnt++;
                    if (m_dlast) last_cnt++;
                end
                hold_pend = m_dvalid && !m_dready;
                hold_dat  = m_data_out;
                hold_last = m_dlast;
                err_pend  = 1'b0;
                if (s_dvalid && !s_dready) sdr_low_seen = 1;
                if (s_dvalid && s_dready) begin
                    if (part_q.size() == N - 1) begin
                        part_q.push_back(s_data_in);
                        for (int i = N - CP; i < N; i++) exp_q.push_back({1'b0, part_q[i]});
                        for (int i = 0; i < N; i++) exp_q.push_back({i == N - 1, part_q[i]});
                        err_pend = !s_dlast;
                        in_done_edge = cyc + 1;
                        part_q.delete();
                    end else if (s_dlast) begin
                        err_pend = 1'b1;
                        part_q.delete();
                    end else begin
                        part_q.push_back(s_data_in);
                    end
                end
            end
        end
    end

    always @(negedge aclk) begin
        if (mon_en && !reset && z_m_dvalid && z_m_dready) z_q.push_back({z_m_dlast, z_m_data});
    end

    task automatic send(input logic [31:0] d, input logic l);
        bit ok = 0;
        s_data_in = d;
        s_dlast   = l;
        s_dvalid  = 1'b1;
        for (int t = 0; t < 400 && !ok; t++) begin
            @(negedge aclk);
            ok = s_dready;
            @(posedge aclk);
            #1;
        end
        check("send_accepted", ok, 1);
        s_dvalid = 1'b0;
        s_dlast  = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 1000 && (exp_q.size() != 0 || m_dvalid); t++) @(negedge aclk);
        check("drain_empty", exp_q.size(), 0);
        @(posedge aclk);
        #1;
    endtask

    int b0, e0;

    initial begin
        repeat (3) @(posedge aclk);
        #1;
        reset = 1'b0;
        check("rst_s_dready", s_dready, 1);
        check("rst_m_dvalid", m_dvalid, 0);
        check("rst_m_dlast", m_dlast, 0);
        check("rst_m_data", m_data_out, 0);
        check("rst_frame_err", frame_err, 0);
        mon_en = 1;

        // single frame with literal pins
        act_log.delete();
        first_vld_edge = -1;
        last_cnt = 0;
        for (int i = 0; i < N; i++) send(32'(i), i == N - 1);
        drain();
        check("sf_beats", act_log.size(), 20);
        if (act_log.size() == 20) begin
            check("sf_beat0", act_log[0], 12);
            check("sf_beat3", act_log[3], 15);
            check("sf_beat4", act_log[4], 0);
            check("sf_beat19", act_log[19], 15);
        end
        check("sf_last_cnt", last_cnt, 1);
        check("sf_latency", first_vld_edge - in_done_edge, 2);

        // back-to-back frames
        vld_first = -1;
        vld_cnt = 0;
        sdr_low_seen = 0;
        b0 = beat_cnt;
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < N; i++) send(32'(k * 16 + i), i == N - 1);
        drain();
        check("b2b_beats", beat_cnt - b0, 80);
        check("b2b_vld_cycles", vld_cnt, 80);
        check("b2b_contiguous", vld_last - vld_first + 1, 80);
        check("b2b_throttled", sdr_low_seen, 1);

        // random backpressure, random data
        bp_en = 1;
        b0 = beat_cnt;
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < N; i++) send($urandom, i == N - 1);
        drain();
        bp_en = 0;
        check("bp_beats", beat_cnt - b0, 60);

        // framing errors
        e0 = err_cnt;
        b0 = beat_cnt;
        for (int i = 0; i < 10; i++) send(32'(200 + i), i == 9);
        repeat (40) @(posedge aclk);
        #1;
        check("short_err", err_cnt - e0, 1);
        check("short_no_out", beat_cnt - b0, 0);
        for (int i = 0; i < N; i++) send(32'(300 + i), 1'b0);
        drain();
        check("nolast_err", err_cnt - e0, 2);
        check("nolast_out", beat_cnt - b0, 20);

        // reset mid-operation
        b0 = beat_cnt;
        for (int i = 0; i < N; i++) send(32'(400 + i), i == N - 1);
        for (int j = 0; j < 12 && (beat_cnt - b0) < 7; j++) send(32'(500 + j), 1'b0);
        check("mid_active", m_dvalid, 1);
        reset = 1'b1;
        @(posedge aclk);
        #1;
        reset = 1'b0;
        check("mid_rst_vld", m_dvalid, 0);
        check("mid_rst_rdy", s_dready, 1);
        b0 = beat_cnt;
        for (int i = 0; i < N; i++) send(32'(600 + i), i == N - 1);
        drain();
        check("post_rst_beats", beat_cnt - b0, 20);

        // CP_LEN=0 instance
        z_q.delete();
        for (int i = 0; i < N; i++) begin
            bit ok;
            z_s_data = 32'(i);
            z_s_dlast = (i == N - 1);
            z_s_dvalid = 1'b1;
            @(negedge aclk);
            ok = z_s_dready;
            @(posedge aclk);
            #1;
            check("z_accepted", ok, 1);
        end
        z_s_dvalid = 1'b0;
        z_s_dlast = 1'b0;
        repeat (40) @(posedge aclk);
        #1;
        check("z_beats", z_q.size(), 16);
        for (int i = 0; i < N && i < z_q.size(); i++) begin
            check("z_dat", z_q[i][31:0], i);
            check("z_last", z_q[i][32], i == N - 1);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
